// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode map, FSM states, word width.
package inst_sequencer_pkg;
  localparam int INST_W = 16;

  localparam logic [3:0] OP_HLT = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JMZ = 4'h6;
  localparam logic [3:0] OP_NI7 = 4'h7;
  localparam logic [3:0] OP_NI8 = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_OR  = 4'ha;
  localparam logic [3:0] OP_NIB = 4'hb;
  localparam logic [3:0] OP_NIC = 4'hc;
  localparam logic [3:0] OP_XOR = 4'hd;
  localparam logic [3:0] OP_NIE = 4'he;
  localparam logic [3:0] OP_RES = 4'hf;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_ARG,
    EXEC,
    HALT
  } seq_state_e;
endpackage

// File: rtl/inst_sequencer_if.sv
// Memory port, decoder handshake and datapath status seen by the sequencer.
interface inst_sequencer_if
  import inst_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;
  logic              dec_enable;
  logic [INST_W-1:0] dec_inst;
  logic [INST_W-1:0] operand;
  logic              ctl_hlt;
  logic              ctl_jmp;
  logic              ctl_jmz;
  logic              acc_zero;
  logic              exec_busy;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    input  start, mem_ack, mem_rdata, ctl_hlt, ctl_jmp, ctl_jmz, acc_zero, exec_busy,
    output mem_req, mem_addr, dec_enable, dec_inst, operand, pc, halted
  );

  modport slave (
    output start, mem_ack, mem_rdata, ctl_hlt, ctl_jmp, ctl_jmz, acc_zero, exec_busy,
    input  mem_req, mem_addr, dec_enable, dec_inst, operand, pc, halted
  );
endinterface

// File: rtl/inst_sequencer.sv
// Fetch/control stage: fetches two-word instructions, hands the opcode to the decoder
// and resolves hlt/jmp/jmz from the decoder's controls.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  inst_sequencer_if.master bus
);
  seq_state_e        state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_arg;
  logic [INST_W-1:0] inst_q;
  logic [INST_W-1:0] arg_q;
  logic              take_branch;

  assign pc_arg      = pc_q + ADDR_W'(1);
  assign take_branch = bus.ctl_jmp | (bus.ctl_jmz & bus.acc_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc_q   <= START_ADDR;
      inst_q <= '0;
      arg_q  <= '0;
    end else begin
      case (state)
        IDLE, HALT: if (bus.start) begin
          pc_q  <= START_ADDR;
          state <= FETCH_OP;
        end
        FETCH_OP: if (bus.mem_ack) begin
          inst_q <= bus.mem_rdata;
          state  <= FETCH_ARG;
        end
        FETCH_ARG: if (bus.mem_ack) begin
          arg_q <= bus.mem_rdata;
          state <= EXEC;
        end
        // hlt leaves pc on the halting instruction; busy re-evaluates controls next cycle
        EXEC: if (!bus.exec_busy) begin
          if (bus.ctl_hlt) begin
            state <= HALT;
          end else begin
            pc_q  <= take_branch ? arg_q[ADDR_W-1:0] : pc_q + ADDR_W'(2);
            state <= FETCH_OP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req    = (state == FETCH_OP) || (state == FETCH_ARG);
  assign bus.mem_addr   = (state == FETCH_ARG) ? pc_arg :
                          (state == FETCH_OP)  ? pc_q   : '0;
  assign bus.dec_enable = (state == EXEC);
  assign bus.halted     = (state == HALT);
  assign bus.dec_inst   = inst_q;
  assign bus.operand    = arg_q;
  assign bus.pc         = pc_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// Random and directed programs for inst_sequencer, checked by an instruction-level interpreter.
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_sequencer_if #(.ADDR_W(16)) dif ();
  inst_sequencer_if #(.ADDR_W(4))  dif4 ();

  inst_sequencer #(.ADDR_W(16), .START_ADDR(16'h0)) dut  (.clk(clk), .rst(rst), .bus(dif.master));
  inst_sequencer #(.ADDR_W(4),  .START_ADDR(4'h0))  dut4 (.clk(clk), .rst(rst), .bus(dif4.master));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // main memory: 256 words, aliased over the 16-bit space, programmable ack latency
  logic [15:0] mem [256];
  int lat  = 0;
  int wcnt = 0;
  always @(posedge clk) wcnt <= (dif.mem_req && !dif.mem_ack) ? wcnt + 1 : 0;
  assign dif.mem_ack   = dif.mem_req && (wcnt >= lat);
  assign dif.mem_rdata = dif.mem_ack ? mem[dif.mem_addr[7:0]] : 16'hdead;
  assign dif.ctl_hlt   = dif.dec_enable && dif.dec_inst[3:0] == OP_HLT;
  assign dif.ctl_jmp   = dif.dec_enable && dif.dec_inst[3:0] == OP_JMP;
  assign dif.ctl_jmz   = dif.dec_enable && dif.dec_inst[3:0] == OP_JMZ;

  // narrow instance: zero-latency 16-word memory
  logic [15:0] mem4 [16];
  assign dif4.mem_ack   = dif4.mem_req;
  assign dif4.mem_rdata = mem4[dif4.mem_addr];
  assign dif4.ctl_hlt   = dif4.dec_enable && dif4.dec_inst[3:0] == OP_HLT;
  assign dif4.ctl_jmp   = dif4.dec_enable && dif4.dec_inst[3:0] == OP_JMP;
  assign dif4.ctl_jmz   = dif4.dec_enable && dif4.dec_inst[3:0] == OP_JMZ;
  assign dif4.acc_zero  = 1'b0;
  assign dif4.exec_busy = 1'b0;

  logic [3:0] plain_ops [13] = '{OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_NI7, OP_NI8, OP_AND,
                                 OP_OR, OP_NIB, OP_NIC, OP_XOR, OP_NIE, OP_RES};

  // model: 0 fetch opcode, 1 fetch operand, 2 execute, 3 idle/halted
  logic [15:0] m_pc = 16'h0;
  int  m_phase   = 3;
  bit  start_req = 0;
  bit  chk_halt  = 0;
  bit  noise_en  = 0;
  int  az_mode   = 0;
  int  busy_mode = 0;
  int  ninst     = 0;
  int  en_cnt    = 0;
  int  busy_cnt  = 0;
  bit  az_cur    = 0;
  bit  seen [256];

  initial begin : mon
    int ph;
    bit busy, stall_v;
    logic [15:0] stall_addr, a1, arg;
    logic [3:0] op;
    stall_v = 0;
    stall_addr = '0;
    dif.start = 1'b0;
    dif.acc_zero = 1'b0;
    dif.exec_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dif.start = 1'b0;
        stall_v = 0;
      end else begin
        if (chk_halt) begin
          chk("halt_flag", dif.halted, 1);
          chk("halt_pc", dif.pc, m_pc);
          chk_halt = 0;
        end
        ph = m_phase;
        if (start_req && ph == 3) begin
          dif.start = 1'b1;
          start_req = 0;
          m_pc = 16'h0;
          m_phase = 0;
        end else begin
          dif.start = noise_en && ph != 3 && $urandom_range(0, 7) == 0;
        end
        if (ph != 2) begin
          az_cur = (az_mode == 2) ? 1'($urandom_range(0, 1)) : az_mode[0];
          dif.acc_zero = az_cur;
          dif.exec_busy = busy_mode != 0 && $urandom_range(0, 1) == 1;
        end
        if (stall_v) begin
          chk("req_held", dif.mem_req, 1);
          chk("addr_stable", dif.mem_addr, stall_addr);
        end
        stall_v = dif.mem_req && !dif.mem_ack;
        stall_addr = dif.mem_addr;
        if (dif.dec_enable) en_cnt++;
        if (dif.mem_req && dif.mem_ack) seen[dif.mem_addr[7:0]] = 1'b1;
        case (ph)
          0, 1: begin
            chk("dec_en_fetch", dif.dec_enable, 0);
            chk("halted_run", dif.halted, 0);
            if (dif.mem_req && dif.mem_ack) begin
              a1 = m_pc + 16'd1;
              chk(ph == 0 ? "op_addr" : "arg_addr", dif.mem_addr, ph == 0 ? m_pc : a1);
              if (ph == 0) m_phase = 1;
              else begin
                m_phase = 2;
                busy_cnt = 0;
              end
            end
          end
          2: begin
            a1 = m_pc + 16'd1;
            chk("dec_en_exec", dif.dec_enable, 1);
            chk("req_exec", dif.mem_req, 0);
            chk("exec_pc", dif.pc, m_pc);
            chk("dec_inst", dif.dec_inst, mem[m_pc[7:0]]);
            chk("operand", dif.operand, mem[a1[7:0]]);
            case (busy_mode)
              2:       busy = busy_cnt < 2;
              1:       busy = busy_cnt < 3 && $urandom_range(0, 2) == 0;
              default: busy = 0;
            endcase
            dif.exec_busy = busy;
            if (busy) busy_cnt++;
            else begin
              op  = mem[m_pc[7:0]][3:0];
              arg = mem[a1[7:0]];
              ninst++;
              if (op == OP_HLT) begin
                m_phase = 3;
                chk_halt = 1;
              end else begin
                m_pc = (op == OP_JMP || (op == OP_JMZ && az_cur)) ? arg : m_pc + 16'd2;
                m_phase = 0;
              end
            end
          end
          default: begin
            chk("req_stop", dif.mem_req, 0);
            chk("dec_en_stop", dif.dec_enable, 0);
          end
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    m_phase = 3;
    m_pc = 16'h0;
    start_req = 0;
    chk_halt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int max_inst);
    int cyc;
    cyc = 0;
    ninst = 0;
    en_cnt = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    start_req = 1;
    while (!(start_req == 0 && m_phase == 3 && !chk_halt) && ninst < max_inst && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("run_budget", cyc < 3000, 1);
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 16'h0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, dif.mem_req, 0);
    chk({tag, "_addr"}, dif.mem_addr, 0);
    chk({tag, "_en"}, dif.dec_enable, 0);
    chk({tag, "_inst"}, dif.dec_inst, 0);
    chk({tag, "_opnd"}, dif.operand, 0);
    chk({tag, "_pc"}, dif.pc, 0);
    chk({tag, "_halted"}, dif.halted, 0);
  endtask

  logic [15:0] w_pc   [4] = '{16'h0, 16'hf, 16'h1, 16'h3};
  logic [15:0] w_inst [4] = '{16'h5, 16'h1, 16'hf, 16'h0};
  logic [15:0] w_arg  [4] = '{16'hf, 16'h5, 16'haa, 16'hbb};

  initial begin : stim
    logic [15:0] q_pc [$];
    logic [15:0] q_inst [$];
    logic [15:0] q_arg [$];
    int cyc;
    dif4.start = 1'b0;
    clear_mem();
    foreach (mem4[i]) mem4[i] = 16'h0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    // narrow pc: operand of pc=0xf comes from address 0, pc+2 wraps to 1
    mem4[0] = 16'h5; mem4[1] = 16'hf; mem4[2] = 16'haa; mem4[4] = 16'hbb; mem4[15] = 16'h1;
    @(negedge clk); dif4.start = 1'b1;
    @(negedge clk); dif4.start = 1'b0;
    for (int i = 0; i < 40 && !dif4.halted; i++) begin
      if (dif4.dec_enable) begin
        q_pc.push_back(16'(dif4.pc));
        q_inst.push_back(dif4.dec_inst);
        q_arg.push_back(dif4.operand);
      end
      @(negedge clk);
    end
    chk("w_halted", dif4.halted, 1);
    chk("w_pc_final", dif4.pc, 4'h3);
    chk("w_count", q_pc.size(), 4);
    for (int i = 0; i < 4 && i < q_pc.size(); i++) begin
      chk("w_pc", q_pc[i], w_pc[i]);
      chk("w_inst", q_inst[i], w_inst[i]);
      chk("w_arg", q_arg[i], w_arg[i]);
    end

    // lda 0x55 then hlt, zero-latency memory
    clear_mem();
    mem[0] = 16'h1; mem[1] = 16'h55;
    run(10);
    chk("t1_ninst", ninst, 2);
    chk("t1_pc", dif.pc, 2);
    chk("t1_halted", dif.halted, 1);
    chk("t1_en_cycles", en_cnt, 2);

    // jmp over 2/3 straight to a halt at 0x10
    clear_mem();
    mem[0] = 16'h5; mem[1] = 16'h10; mem[2] = 16'h1; mem[3] = 16'h77;
    run(10);
    chk("t2_pc", dif.pc, 16'h10);
    chk("t2_no_addr2", seen[2], 0);
    chk("t2_no_addr3", seen[3], 0);
    chk("t2_addr10", seen[16], 1);

    // jmz at 4: not taken halts at 6, taken halts at 0x20
    clear_mem();
    mem[0] = 16'h5; mem[1] = 16'h4; mem[4] = 16'h6; mem[5] = 16'h20;
    az_mode = 0;
    run(10);
    chk("t3_nz_pc", dif.pc, 16'h6);
    az_mode = 1;
    run(10);
    chk("t3_z_pc", dif.pc, 16'h20);
    az_mode = 0;

    // slow memory plus two busy cycles per instruction
    clear_mem();
    mem[0] = 16'h1; mem[1] = 16'h55;
    lat = 3; busy_mode = 2;
    run(10);
    chk("t4_pc", dif.pc, 2);
    chk("t4_en_cycles", en_cnt, 6);
    busy_mode = 0;

    // reset while the operand fetch is outstanding
    start_req = 1;
    cyc = 0;
    while (m_phase != 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_reach_arg", cyc < 50, 1);
    @(posedge clk);
    #3;
    chk("t5_mid_req", dif.mem_req, 1);
    chk("t5_mid_addr", dif.mem_addr, 1);
    rst = 1'b1;
    m_phase = 3; m_pc = 16'h0; start_req = 0; chk_halt = 0;
    #1;
    chk_reset_vals("t5");
    @(negedge clk);
    rst = 1'b0;
    run(10);
    chk("t5_rerun_pc", dif.pc, 2);
    chk("t5_rerun_addr0", seen[0], 1);

    // random programs with stalls, random acc_zero and stray start pulses
    noise_en = 1; az_mode = 2; busy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < 256; a++) begin
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 19);
        op = plain_ops[$urandom_range(0, 12)];
        if (r < 2) op = OP_HLT;
        else if (r < 5) op = OP_JMP;
        else if (r < 9) op = OP_JMZ;
        mem[a] = {12'($urandom), op};
      end
      lat = $urandom_range(0, 3);
      run(30);
      if (m_phase != 3) do_reset();
    end
    noise_en = 0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
